// File: rtl/tlb_op_sequencer.sv
// TLB operation sequencer.
// Takes TLBR/TLBWI/TLBWR/TLBP from the execute stage and drives the TLB
// management port. Captures read and probe results for CP0 and strobes them
// into CP0. It also owns the MIPS Random register.
module tlb_op_sequencer #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [1:0]       op_type,
    output logic             op_ready,
    output logic             stall,
    input  logic [IDX_W-1:0] cp0_index,
    input  logic [IDX_W-1:0] cp0_wired,
    input  logic             wired_we,
    output logic [IDX_W-1:0] tlb_rw_index,
    output logic             tlb_rw_we,
    input  logic [31:0]      tlb_p_index,
    input  logic [31:0]      entry_hi_o,
    input  logic [31:0]      entry_lo1_o,
    input  logic [31:0]      entry_lo2_o,
    output logic [IDX_W-1:0] random_o,
    output logic             cp0_entry_we,
    output logic [31:0]      entry_hi_r,
    output logic [31:0]      entry_lo1_r,
    output logic [31:0]      entry_lo2_r,
    output logic             cp0_index_we,
    output logic [31:0]      index_r,
    output logic             flush_o,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        PROBE2 = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [1:0] OP_TLBR  = 2'b00;
    localparam logic [1:0] OP_TLBWI = 2'b01;
    localparam logic [1:0] OP_TLBWR = 2'b10;
    localparam logic [1:0] OP_TLBP  = 2'b11;

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(TLB_ENTRIES - 1);

    state_t           state;
    state_t           state_next;
    logic [1:0]       op_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] random_q;
    logic             accept;
    logic             is_write;

    assign is_write     = (op_q == OP_TLBWI) || (op_q == OP_TLBWR);
    assign tlb_rw_index = idx_q;
    assign random_o     = random_q;

    // State register; reset abandons any op in flight immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the handshake, stall and strobe outputs.
    always_comb begin
        state_next   = state;
        op_ready     = 1'b0;
        stall        = 1'b0;
        accept       = 1'b0;
        tlb_rw_we    = 1'b0;
        cp0_entry_we = 1'b0;
        cp0_index_we = 1'b0;
        flush_o      = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                op_ready = 1'b1;
                stall    = op_valid;
                if (op_valid) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                stall      = 1'b1;
                tlb_rw_we  = is_write;
                state_next = (op_q == OP_TLBP) ? PROBE2 : DONE;
            end
            PROBE2: begin
                stall      = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done         = 1'b1;
                cp0_entry_we = (op_q == OP_TLBR);
                cp0_index_we = (op_q == OP_TLBP);
                flush_o      = is_write;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the op and its target index on accept; TLBWR takes Random as it is before this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q  <= OP_TLBR;
            idx_q <= '0;
        end else if (accept) begin
            op_q  <= op_type;
            idx_q <= (op_type == OP_TLBWR) ? random_q : cp0_index;
        end
    end

    // Random register: counts down from the top entry to Wired and wraps, independent of ops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            random_q <= MAX_IDX;
        end else if (wired_we) begin
            random_q <= MAX_IDX;
        end else if (cp0_wired >= MAX_IDX) begin
            random_q <= MAX_IDX;
        end else if (random_q <= cp0_wired) begin
            random_q <= MAX_IDX;
        end else begin
            random_q <= random_q - 1'b1;
        end
    end

    // Capture the TLB read data at the end of the TLBR execute cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_hi_r  <= '0;
            entry_lo1_r <= '0;
            entry_lo2_r <= '0;
        end else if (state == EXEC && op_q == OP_TLBR) begin
            entry_hi_r  <= entry_hi_o;
            entry_lo1_r <= entry_lo1_o;
            entry_lo2_r <= entry_lo2_o;
        end
    end

    // Capture the probe result one cycle after the probe lookup was presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            index_r <= '0;
        end else if (state == PROBE2) begin
            index_r <= tlb_p_index;
        end
    end

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Testbench for tlb_op_sequencer.
// Expected TLB writes and op completions are queued as ops are issued.
// A negedge monitor pops the queues and checks every write strobe and done pulse.
module tb_tlb_op_sequencer;

    localparam logic [1:0] OP_TLBR  = 2'b00;
    localparam logic [1:0] OP_TLBWI = 2'b01;
    localparam logic [1:0] OP_TLBWR = 2'b10;
    localparam logic [1:0] OP_TLBP  = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [1:0]  op_type = 2'b00;
    logic        op_ready;
    logic        stall;
    logic [3:0]  cp0_index = 4'd0;
    logic [3:0]  cp0_wired = 4'd0;
    logic        wired_we = 1'b0;
    logic [3:0]  tlb_rw_index;
    logic        tlb_rw_we;
    logic [31:0] tlb_p_index = 32'h0;
    logic [31:0] entry_hi_o = 32'h0;
    logic [31:0] entry_lo1_o = 32'h0;
    logic [31:0] entry_lo2_o = 32'h0;
    logic [3:0]  random_o;
    logic        cp0_entry_we;
    logic [31:0] entry_hi_r;
    logic [31:0] entry_lo1_r;
    logic [31:0] entry_lo2_r;
    logic        cp0_index_we;
    logic [31:0] index_r;
    logic        flush_o;
    logic        done;

    typedef struct packed {
        logic        flush;
        logic        entry_we;
        logic        index_we;
        logic [31:0] hi;
        logic [31:0] lo1;
        logic [31:0] lo2;
        logic [31:0] idx;
    } done_t;

    done_t      done_q[$];
    logic [3:0] write_q[$];

    int checks = 0;
    int errors = 0;

    logic [31:0] model_hi  = 32'h0;
    logic [31:0] model_lo1 = 32'h0;
    logic [31:0] model_lo2 = 32'h0;
    logic [31:0] model_idx = 32'h0;

    tlb_op_sequencer #(.TLB_ENTRIES(16), .IDX_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op_type      (op_type),
        .op_ready     (op_ready),
        .stall        (stall),
        .cp0_index    (cp0_index),
        .cp0_wired    (cp0_wired),
        .wired_we     (wired_we),
        .tlb_rw_index (tlb_rw_index),
        .tlb_rw_we    (tlb_rw_we),
        .tlb_p_index  (tlb_p_index),
        .entry_hi_o   (entry_hi_o),
        .entry_lo1_o  (entry_lo1_o),
        .entry_lo2_o  (entry_lo2_o),
        .random_o     (random_o),
        .cp0_entry_we (cp0_entry_we),
        .entry_hi_r   (entry_hi_r),
        .entry_lo1_r  (entry_lo1_r),
        .entry_lo2_r  (entry_lo2_r),
        .cp0_index_we (cp0_index_we),
        .index_r      (index_r),
        .flush_o      (flush_o),
        .done         (done)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issue one op from IDLE, queue its expectations and follow it to done.
    task automatic applyStimulus(input logic [1:0] t, input logic [3:0] idx, input int lat);
        done_t d;
        int    n;
        @(posedge clk); #1;
        op_valid  = 1'b1;
        op_type   = t;
        cp0_index = idx;
        if (t == OP_TLBR) begin
            model_hi  = entry_hi_o;
            model_lo1 = entry_lo1_o;
            model_lo2 = entry_lo2_o;
        end
        if (t == OP_TLBP) model_idx = tlb_p_index;
        if (t == OP_TLBWI || t == OP_TLBWR) write_q.push_back(idx);
        d.flush    = (t == OP_TLBWI || t == OP_TLBWR);
        d.entry_we = (t == OP_TLBR);
        d.index_we = (t == OP_TLBP);
        d.hi       = model_hi;
        d.lo1      = model_lo1;
        d.lo2      = model_lo2;
        d.idx      = model_idx;
        done_q.push_back(d);
        @(posedge clk); #1;
        op_valid = 1'b0;
        for (n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) checkOutput("exec_index", {28'h0, tlb_rw_index}, {28'h0, idx});
            if (done) break;
            checkOutput("stall_busy", {31'h0, stall}, 32'h1);
        end
        checkOutput("latency", n, lat);
        checkOutput("stall_done", {31'h0, stall}, 32'h0);
    endtask

    // Monitor: every write strobe and every done pulse must match the next queued expectation.
    initial begin
        done_t d;
        forever begin
            @(negedge clk);
            if (tlb_rw_we) begin
                if (write_q.size() == 0) begin
                    checkOutput("unexpected_write", 32'h1, 32'h0);
                end else begin
                    checkOutput("write_index", {28'h0, tlb_rw_index}, {28'h0, write_q.pop_front()});
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checkOutput("unexpected_done", 32'h1, 32'h0);
                end else begin
                    d = done_q.pop_front();
                    checkOutput("flush_o", {31'h0, flush_o}, {31'h0, d.flush});
                    checkOutput("cp0_entry_we", {31'h0, cp0_entry_we}, {31'h0, d.entry_we});
                    checkOutput("cp0_index_we", {31'h0, cp0_index_we}, {31'h0, d.index_we});
                    checkOutput("entry_hi_r", entry_hi_r, d.hi);
                    checkOutput("entry_lo1_r", entry_lo1_r, d.lo1);
                    checkOutput("entry_lo2_r", entry_lo2_r, d.lo2);
                    checkOutput("index_r", index_r, d.idx);
                end
            end else begin
                checkOutput("idle_strobes", {29'h0, flush_o, cp0_entry_we, cp0_index_we}, 32'h0);
            end
        end
    end

    // Directed test sequence.
    initial begin
        logic [3:0] exp_rand;
        int         found;

        // Reset state.
        #12;
        checkOutput("rst_random", {28'h0, random_o}, 32'd15);
        checkOutput("rst_stall", {31'h0, stall}, 32'h0);
        checkOutput("rst_we", {31'h0, tlb_rw_we}, 32'h0);
        checkOutput("rst_index_r", index_r, 32'h0);
        checkOutput("rst_entry_hi_r", entry_hi_r, 32'h0);
        checkOutput("rst_rw_index", {28'h0, tlb_rw_index}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Reset asserted in the middle of a TLBWI execute cycle.
        repeat (3) @(posedge clk);
        #1;
        op_valid  = 1'b1;
        op_type   = OP_TLBWI;
        cp0_index = 4'd5;
        @(posedge clk); #1;
        op_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        checkOutput("reset_we_drop", {31'h0, tlb_rw_we}, 32'h0);
        checkOutput("reset_random", {28'h0, random_o}, 32'd15);
        checkOutput("reset_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_idle_ready", {31'h0, op_ready}, 32'h1);
        checkOutput("reset_done_low", {31'h0, done}, 32'h0);

        // TLBWI to entry 5.
        applyStimulus(OP_TLBWI, 4'd5, 2);

        // TLBR of entry 3.
        entry_hi_o  = 32'h1234_5000;
        entry_lo1_o = 32'h0000_0016;
        entry_lo2_o = 32'h0000_0017;
        applyStimulus(OP_TLBR, 4'd3, 2);

        // TLBP miss, then a hit, then a read to show index_r holds.
        tlb_p_index = 32'h8000_0000;
        applyStimulus(OP_TLBP, 4'd0, 3);
        tlb_p_index = 32'h0000_000B;
        applyStimulus(OP_TLBP, 4'd0, 3);
        entry_hi_o  = 32'hABCD_E000;
        entry_lo1_o = 32'h0000_1234;
        entry_lo2_o = 32'h0000_5678;
        applyStimulus(OP_TLBR, 4'd9, 2);
        applyStimulus(OP_TLBWI, 4'd15, 2);

        // Random counting with Wired = 2.
        @(posedge clk); #1;
        cp0_wired = 4'd2;
        wired_we  = 1'b1;
        @(posedge clk); #1;
        wired_we = 1'b0;
        exp_rand = 4'd15;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checkOutput("random_seq", {28'h0, random_o}, {28'h0, exp_rand});
            exp_rand = (exp_rand <= 4'd2) ? 4'd15 : exp_rand - 4'd1;
        end
        @(posedge clk); #1;
        wired_we = 1'b1;
        @(posedge clk); #1;
        wired_we = 1'b0;
        checkOutput("random_wired_we", {28'h0, random_o}, 32'd15);
        cp0_wired = 4'd15;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("random_hold", {28'h0, random_o}, 32'd15);

        // TLBWR at Random = 9, with a TLBWI to entry 7 held behind it.
        cp0_wired = 4'd0;
        wired_we  = 1'b1;
        @(posedge clk); #1;
        wired_we = 1'b0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (random_o == 4'd9) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        checkOutput("random_reach_9", found, 1);
        op_valid  = 1'b1;
        op_type   = OP_TLBWR;
        write_q.push_back(4'd9);
        done_q.push_back('{flush: 1'b1, entry_we: 1'b0, index_we: 1'b0,
                           hi: model_hi, lo1: model_lo1, lo2: model_lo2, idx: model_idx});
        write_q.push_back(4'd7);
        done_q.push_back('{flush: 1'b1, entry_we: 1'b0, index_we: 1'b0,
                           hi: model_hi, lo1: model_lo1, lo2: model_lo2, idx: model_idx});
        @(posedge clk); #1;
        op_type   = OP_TLBWI;
        cp0_index = 4'd7;
        @(negedge clk);
        checkOutput("wr_exec_index", {28'h0, tlb_rw_index}, 32'd9);
        checkOutput("wr_exec_random", {28'h0, random_o}, 32'd8);
        checkOutput("wr_exec_ready", {31'h0, op_ready}, 32'h0);
        @(negedge clk);
        checkOutput("wr_done", {31'h0, done}, 32'h1);
        checkOutput("wr_done_ready", {31'h0, op_ready}, 32'h0);
        checkOutput("wr_done_we", {31'h0, tlb_rw_we}, 32'h0);
        @(negedge clk);
        checkOutput("held_idle_ready", {31'h0, op_ready}, 32'h1);
        checkOutput("held_idle_stall", {31'h0, stall}, 32'h1);
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(negedge clk);
        checkOutput("held_exec_we", {31'h0, tlb_rw_we}, 32'h1);
        checkOutput("held_exec_index", {28'h0, tlb_rw_index}, 32'd7);
        @(negedge clk);
        checkOutput("held_done", {31'h0, done}, 32'h1);
        repeat (3) @(negedge clk);

        checkOutput("write_queue_empty", write_q.size(), 0);
        checkOutput("done_queue_empty", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
